// File: rtl/tx_pkg.sv
// Shared constants for the QPSK transmit shaper: default RRC table, PRBS9 taps and seeds.
package tx_pkg;

  localparam int unsigned PRBS9_TAP_HI = 8;
  localparam int unsigned PRBS9_TAP_LO = 4;

  localparam logic [8:0] PRBS9_SEED_I = 9'h1AA;
  localparam logic [8:0] PRBS9_SEED_Q = 9'h1FE;

  // 24-tap RRC, S(8,7), coef[0] in the least significant byte.
  localparam logic [24*8-1:0] RRC_COEFS =
    192'h0104_0502_FBF4_F2FA_1937_505A_5037_19FA_F2F4_FB02_0504_0100;

endpackage

// File: rtl/tx_qpsk_shaper_if.sv
// Sample-rate enable in, shaped I/Q samples and symbol taps out.
interface tx_qpsk_shaper_if #(
  parameter int unsigned NBT_OUT = 8
) ();
  logic                       i_en_rate2;
  logic signed [NBT_OUT-1:0]  o_os_data_I;
  logic signed [NBT_OUT-1:0]  o_os_data_Q;
  logic                       o_valid;
  logic                       o_sym_I;
  logic                       o_sym_Q;

  modport master (
    output i_en_rate2,
    input  o_os_data_I, o_os_data_Q, o_valid, o_sym_I, o_sym_Q
  );

  modport slave (
    input  i_en_rate2,
    output o_os_data_I, o_os_data_Q, o_valid, o_sym_I, o_sym_Q
  );
endinterface

// File: rtl/tx_qpsk_shaper_prbs9.sv
// PRBS9 (x^9+x^5+1) Fibonacci generator; o_bit is the current MSB, i_en advances one step.
module prbs9
  import tx_pkg::*;
#(
  parameter logic [8:0] SEED = PRBS9_SEED_I
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_bit
);

  logic [8:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_en) begin
      lfsr_d = {lfsr_q[7:0], lfsr_q[PRBS9_TAP_HI] ^ lfsr_q[PRBS9_TAP_LO]};
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_bit = lfsr_q[8];

endmodule

// File: rtl/tx_qpsk_shaper.sv
// QPSK transmitter: PRBS9 bits per channel, polyphase RRC pulse shaping at OS samples/symbol.
module tx_qpsk_shaper
  import tx_pkg::*;
#(
  parameter int unsigned                 OS       = 4,
  parameter int unsigned                 NUM_TAPS = 24,
  parameter int unsigned                 NBT_COEF = 8,
  parameter int unsigned                 NBF_COEF = 7,
  parameter int unsigned                 NBT_OUT  = 8,
  parameter int unsigned                 NBF_OUT  = 7,
  parameter logic [NUM_TAPS*NBT_COEF-1:0] COEFS   = RRC_COEFS,
  parameter logic [8:0]                  SEED_I   = PRBS9_SEED_I,
  parameter logic [8:0]                  SEED_Q   = PRBS9_SEED_Q
) (
  input  logic             clk,
  input  logic             i_reset,
  tx_qpsk_shaper_if.slave  bus
);

  localparam int unsigned NSYM  = NUM_TAPS / OS;
  localparam int unsigned PH_W  = (OS > 1) ? $clog2(OS) : 1;
  localparam int unsigned ACC_W = NBT_COEF + $clog2(NSYM) + 1;
  localparam int unsigned DROP  = NBF_COEF - NBF_OUT;

  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [NBT_OUT-1:0] out_t;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);
  localparam acc_t            OUT_MAX = acc_t'((1 << (NBT_OUT - 1)) - 1);
  localparam acc_t            OUT_MIN = -acc_t'(1 << (NBT_OUT - 1));

  // Polyphase branch: each stored symbol selects +coef or -coef, no multiplier.
  function automatic acc_t poly_sum(input logic [NSYM-1:0] sym, input logic [PH_W-1:0] ph);
    acc_t                        acc;
    logic signed [NBT_COEF-1:0]  c;
    acc = '0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      c   = COEFS[(k*OS + ph)*NBT_COEF +: NBT_COEF];
      acc = sym[k] ? acc - acc_t'(c) : acc + acc_t'(c);
    end
    return acc;
  endfunction

  function automatic out_t to_out(input acc_t acc);
    acc_t t;
    t = acc >>> DROP;
    if (t > OUT_MAX) begin
      t = OUT_MAX;
    end else if (t < OUT_MIN) begin
      t = OUT_MIN;
    end
    return t[NBT_OUT-1:0];
  endfunction

  logic [PH_W-1:0] phase_q, phase_d;
  logic [NSYM-1:0] sym_ich_q, sym_ich_d;
  logic [NSYM-1:0] sym_qch_q, sym_qch_d;
  out_t            data_i_q, data_i_d;
  out_t            data_q_q, data_q_d;
  logic            valid_q, valid_d;

  logic            bit_i, bit_q;
  logic            sym_adv;

  assign sym_adv = bus.i_en_rate2 && (phase_q == PH_LAST);

  prbs9 #(.SEED(SEED_I)) u_prbs_i (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (sym_adv),
    .o_bit   (bit_i)
  );

  prbs9 #(.SEED(SEED_Q)) u_prbs_q (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (sym_adv),
    .o_bit   (bit_q)
  );

  always_comb begin
    phase_d   = phase_q;
    sym_ich_d = sym_ich_q;
    sym_qch_d = sym_qch_q;
    data_i_d  = data_i_q;
    data_q_d  = data_q_q;
    valid_d   = bus.i_en_rate2;
    if (bus.i_en_rate2) begin
      // Sample uses pre-update phase and symbols; the new bit lands for the next symbol.
      data_i_d = to_out(poly_sum(sym_ich_q, phase_q));
      data_q_d = to_out(poly_sum(sym_qch_q, phase_q));
      if (sym_adv) begin
        phase_d      = '0;
        sym_ich_d[0] = bit_i;
        sym_qch_d[0] = bit_q;
        for (int unsigned k = 1; k < NSYM; k++) begin
          sym_ich_d[k] = sym_ich_q[k-1];
          sym_qch_d[k] = sym_qch_q[k-1];
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase_q   <= '0;
      sym_ich_q <= '0;
      sym_qch_q <= '0;
      data_i_q  <= '0;
      data_q_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      sym_ich_q <= sym_ich_d;
      sym_qch_q <= sym_qch_d;
      data_i_q  <= data_i_d;
      data_q_q  <= data_q_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.o_os_data_I = data_i_q;
  assign bus.o_os_data_Q = data_q_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_sym_I     = sym_ich_q[0];
  assign bus.o_sym_Q     = sym_qch_q[0];

endmodule
